// File: rtl/cpu_types_pkg.sv
// Shared types for the cache-to-RAM arbiter: RAM handshake states, arbiter states,
// the grant owner record and the load word substituted on a RAM error.
package cpu_types_pkg;

  localparam int MAX_CORES = 4;
  localparam int CORE_W    = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ram_state_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [CORE_W-1:0] core;
    logic              is_d;
    logic              is_wr;
  } owner_t;

  localparam word_t BAD_LOAD = 32'hBAD1BAD1;

  // Round-robin successor of core c among n cores.
  function automatic logic [CORE_W-1:0] next_core(input logic [CORE_W-1:0] c, input int n);
    if (int'(c) == n - 1) return '0;
    else                  return c + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin first-set-bit finder: first requester at or after ptr, wrapping modulo N.
module rr_pick
  import cpu_types_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]      req,
  input  logic [CORE_W-1:0] ptr,
  output logic              valid,
  output logic [CORE_W-1:0] idx
);

  logic [MAX_CORES-1:0] req_x;
  logic [CORE_W-1:0]    pos;

  always_comb begin
    req_x          = '0;
    req_x[N-1:0]   = req;
    valid          = 1'b0;
    idx            = '0;
    pos            = '0;
    for (int off = 0; off < N; off++) begin
      pos = (int'(ptr) + off >= N) ? CORE_W'(int'(ptr) + off - N) : CORE_W'(int'(ptr) + off);
      if (!valid && req_x[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache/dcache requests of NCORES cores onto one RAM port.
// Dcache class beats icache class; round-robin across cores within a class.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NCORES  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [NCORES-1:0]    iREN,
  input  logic [NCORES*32-1:0] iaddr,
  input  logic [NCORES-1:0]    dREN,
  input  logic [NCORES-1:0]    dWEN,
  input  logic [NCORES*32-1:0] daddr,
  input  logic [NCORES*32-1:0] dstore,
  output logic [NCORES-1:0]    iwait,
  output logic [NCORES-1:0]    dwait,
  output logic [NCORES*32-1:0] iload,
  output logic [NCORES*32-1:0] dload,
  output logic               ramREN,
  output logic               ramWEN,
  output logic [31:0]        ramaddr,
  output logic [31:0]        ramstore,
  input  logic [31:0]        ramload,
  input  ram_state_t         ramstate,
  output logic               bus_err
);

  localparam int TW = ($clog2(TIMEOUT) + 1 > 7) ? $clog2(TIMEOUT) + 1 : 7;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  arb_state_t        state;
  logic [CORE_W-1:0] rr_ptr;
  owner_t            owner;
  logic [TW-1:0]     tcnt;

  logic [NCORES-1:0]    dreq;
  logic                 d_valid, i_valid;
  logic [CORE_W-1:0]    d_idx, i_idx;
  logic [MAX_CORES-1:0] iren_x, dren_x, dwen_x;
  logic [MAX_CORES-1:0] iwait_x, dwait_x;
  word_t                iaddr_w  [MAX_CORES];
  word_t                daddr_w  [MAX_CORES];
  word_t                dstore_w [MAX_CORES];
  logic                 o_active, hit, expire, done;
  word_t                load_word;

  assign dreq = dREN | dWEN;

  rr_pick #(.N(NCORES)) u_pick_d (
    .req   (dreq),
    .ptr   (rr_ptr),
    .valid (d_valid),
    .idx   (d_idx)
  );

  rr_pick #(.N(NCORES)) u_pick_i (
    .req   (iREN),
    .ptr   (rr_ptr),
    .valid (i_valid),
    .idx   (i_idx)
  );

  // Widen per-core inputs to MAX_CORES so the 2-bit owner index selects them directly.
  always_comb begin
    iren_x = '0;
    dren_x = '0;
    dwen_x = '0;
    iren_x[NCORES-1:0] = iREN;
    dren_x[NCORES-1:0] = dREN;
    dwen_x[NCORES-1:0] = dWEN;
    for (int c = 0; c < MAX_CORES; c++) begin
      iaddr_w[c]  = '0;
      daddr_w[c]  = '0;
      dstore_w[c] = '0;
    end
    for (int c = 0; c < NCORES; c++) begin
      iaddr_w[c]  = iaddr[c*32 +: 32];
      daddr_w[c]  = daddr[c*32 +: 32];
      dstore_w[c] = dstore[c*32 +: 32];
    end
  end

  // The owner's live request keeps the grant alive; dropping it abandons the access.
  always_comb begin
    o_active = 1'b0;
    if (state == GRANT) begin
      if (owner.is_d) o_active = owner.is_wr ? dwen_x[owner.core] : dren_x[owner.core];
      else            o_active = iren_x[owner.core];
    end
    hit    = (ramstate == ACCESS) || (ramstate == ERROR);
    expire = (tcnt == TLAST);
    done   = o_active && (hit || expire);
  end

  always_comb begin
    ramREN   = o_active && !owner.is_wr;
    ramWEN   = o_active && owner.is_wr;
    ramaddr  = '0;
    ramstore = '0;
    if (o_active) begin
      ramaddr = owner.is_d ? daddr_w[owner.core] : iaddr_w[owner.core];
      if (owner.is_wr) ramstore = dstore_w[owner.core];
    end
  end

  always_comb begin
    iwait_x = '1;
    dwait_x = '1;
    if (done) begin
      if (owner.is_d) dwait_x[owner.core] = 1'b0;
      else            iwait_x[owner.core] = 1'b0;
    end
  end

  assign iwait     = iwait_x[NCORES-1:0];
  assign dwait     = dwait_x[NCORES-1:0];
  assign load_word = (o_active && ramstate == ERROR) ? BAD_LOAD : ramload;
  assign iload     = {NCORES{load_word}};
  assign dload     = {NCORES{load_word}};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      tcnt    <= '0;
      bus_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (d_valid) begin
            owner <= '{core: d_idx, is_d: 1'b1, is_wr: dwen_x[d_idx]};
            state <= GRANT;
          end else if (i_valid) begin
            owner <= '{core: i_idx, is_d: 1'b0, is_wr: 1'b0};
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!o_active) begin
            state <= IDLE;
            tcnt  <= '0;
          end else if (done) begin
            state  <= IDLE;
            tcnt   <= '0;
            rr_ptr <= next_core(owner.core, NCORES);
            // Anything other than a clean ACCESS (ERROR or timeout) is sticky.
            if (ramstate != ACCESS) bus_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-scenario tasks with inline checks, plus a completion
// scoreboard fed by the tasks and drained whenever a wait goes low.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int NC = 2;
  localparam int TO = 8;

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic [NC-1:0]    iREN, dREN, dWEN;
  logic [NC*32-1:0] iaddr, daddr, dstore;
  logic [NC-1:0]    iwait, dwait;
  logic [NC*32-1:0] iload, dload;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  ram_state_t       ramstate;
  logic             bus_err;

  mem_arbiter #(.NCORES(NC), .TIMEOUT(TO)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .iwait    (iwait),
    .dwait    (dwait),
    .iload    (iload),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .bus_err  (bus_err)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        is_d;
    logic [1:0]  core;
    logic [31:0] data;
  } cpl_t;

  cpl_t exp_q[$];
  cpl_t mon_got, mon_exp;
  int   mon_lows;

  // Completion scoreboard: every low wait must match the next expected completion.
  always @(negedge CLK) begin
    if (nRST) begin
      mon_lows = 0;
      for (int c = 0; c < NC; c++) begin
        for (int k = 0; k < 2; k++) begin
          if ((k == 0 ? iwait[c] : dwait[c]) === 1'b0) begin
            mon_lows++;
            checks++;
            mon_got.is_d = (k == 1);
            mon_got.core = 2'(c);
            mon_got.data = (k == 0) ? iload[c*32 +: 32] : dload[c*32 +: 32];
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL cpl_unexpected: is_d=%0d core=%0d completed, none expected", k, c);
            end else begin
              mon_exp = exp_q.pop_front();
              if (mon_got !== mon_exp) begin
                errors++;
                $display("FAIL cpl_match: got is_d=%0d core=%0d data=%h, expected is_d=%0d core=%0d data=%h",
                         mon_got.is_d, mon_got.core, mon_got.data, mon_exp.is_d, mon_exp.core, mon_exp.data);
              end
            end
          end
        end
      end
      if (mon_lows > 0) begin
        checks++;
        if (mon_lows > 1) begin
          errors++;
          $display("FAIL cpl_overlap: %0d waits low in one cycle, expected 1", mon_lows);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    clear_inputs();
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    tick();
  endtask

  task automatic push(input logic is_d, input logic [1:0] core, input logic [31:0] data);
    cpl_t e;
    e.is_d = is_d; e.core = core; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    clear_inputs();
    ramload = 32'hA5A5_0F0F;
    iREN = 2'b11;
    @(negedge CLK);
    checks++; if ({ramREN, ramWEN} !== 2'b00) begin errors++; $display("FAIL reset_en: got %b expected 00", {ramREN, ramWEN}); end
    checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h/%h expected 0/0", ramaddr, ramstore); end
    checks++; if (iwait !== 2'b11 || dwait !== 2'b11) begin errors++; $display("FAIL reset_wait: got %b/%b expected 11/11", iwait, dwait); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b expected 0", bus_err); end
    checks++; if (iload !== {2{32'hA5A5_0F0F}} || dload !== {2{32'hA5A5_0F0F}}) begin errors++; $display("FAIL reset_load: got %h/%h expected broadcast a5a50f0f", iload, dload); end
    iREN = '0;
    @(posedge CLK);
    #1 nRST = 1'b1;
    tick();
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL reset_idle: got ramREN=%b expected 0", ramREN); end
  endtask

  task automatic test_round_robin();
    logic [31:0] ea;
    dREN = 2'b11;
    daddr = {32'h0000_0300, 32'h0000_0200};
    ramstate = ACCESS;
    ramload = 32'h3333_0000;
    for (int g = 0; g < 4; g++) push(1'b1, 2'(g % 2), 32'h3333_0000);
    for (int g = 0; g < 4; g++) begin
      tick();
      @(negedge CLK);
      ea = (g % 2 == 1) ? 32'h300 : 32'h200;
      checks++; if (ramREN !== 1'b1 || ramaddr !== ea) begin errors++; $display("FAIL rr_grant%0d: got ren=%b addr=%h expected 1/%h", g, ramREN, ramaddr, ea); end
      checks++; if (dwait !== ((g % 2 == 1) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rr_dwait%0d: got %b", g, dwait); end
      tick();
      if (g == 3) dREN = '0;
      @(negedge CLK);
      checks++; if ({ramREN, ramWEN} !== 2'b00) begin errors++; $display("FAIL rr_bubble%0d: got %b expected 00", g, {ramREN, ramWEN}); end
    end
  endtask

  task automatic test_single_read();
    iREN = 2'b01;
    iaddr[31:0] = 32'h40;
    ramstate = BUSY;
    ramload = 32'h1234_5678;
    push(1'b0, 2'd0, 32'h1234_5678);
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 3) ramstate = ACCESS;
      @(negedge CLK);
      checks++; if ({ramREN, ramWEN} !== 2'b10 || ramaddr !== 32'h40) begin errors++; $display("FAIL read_bus%0d: got en=%b addr=%h expected 10/40", k, {ramREN, ramWEN}, ramaddr); end
      checks++; if (iwait !== ((k == 3) ? 2'b10 : 2'b11)) begin errors++; $display("FAIL read_iwait%0d: got %b", k, iwait); end
      if (k == 3) begin
        checks++; if (iload[31:0] !== 32'h1234_5678) begin errors++; $display("FAIL read_data: got %h expected 12345678", iload[31:0]); end
      end
    end
    tick();
    iREN = '0;
    ramstate = FREE;
    @(negedge CLK);
    checks++; if ({ramREN, ramWEN} !== 2'b00) begin errors++; $display("FAIL read_release: got %b expected 00", {ramREN, ramWEN}); end
  endtask

  task automatic test_priority();
    iREN = 2'b01;
    iaddr[31:0] = 32'h100;
    dWEN = 2'b10;
    daddr[63:32] = 32'h80;
    dstore[63:32] = 32'hCAFE;
    ramstate = ACCESS;
    ramload = 32'h0000_5555;
    push(1'b1, 2'd1, 32'h0000_5555);
    push(1'b0, 2'd0, 32'h0000_5555);
    tick();
    @(negedge CLK);
    checks++; if ({ramREN, ramWEN} !== 2'b01 || ramaddr !== 32'h80 || ramstore !== 32'hCAFE) begin errors++; $display("FAIL prio_write: got en=%b addr=%h store=%h expected 01/80/cafe", {ramREN, ramWEN}, ramaddr, ramstore); end
    checks++; if (dwait !== 2'b01 || iwait !== 2'b11) begin errors++; $display("FAIL prio_waits: got d=%b i=%b expected 01/11", dwait, iwait); end
    tick();
    dWEN = '0;
    @(negedge CLK);
    checks++; if ({ramREN, ramWEN} !== 2'b00) begin errors++; $display("FAIL prio_bubble: got %b expected 00", {ramREN, ramWEN}); end
    tick();
    @(negedge CLK);
    checks++; if ({ramREN, ramWEN} !== 2'b10 || ramaddr !== 32'h100 || ramstore !== 32'h0) begin errors++; $display("FAIL prio_read: got en=%b addr=%h store=%h expected 10/100/0", {ramREN, ramWEN}, ramaddr, ramstore); end
    checks++; if (iwait !== 2'b10) begin errors++; $display("FAIL prio_iwait: got %b expected 10", iwait); end
    tick();
    iREN = '0;
    @(negedge CLK);
  endtask

  task automatic test_timeout();
    iREN = 2'b10;
    iaddr[63:32] = 32'h500;
    ramstate = BUSY;
    ramload = 32'h0000_7777;
    push(1'b0, 2'd1, 32'h0000_7777);
    for (int g = 1; g <= TO; g++) begin
      tick();
      @(negedge CLK);
      checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin errors++; $display("FAIL to_bus%0d: got ren=%b addr=%h expected 1/500", g, ramREN, ramaddr); end
      checks++; if (iwait !== ((g == TO) ? 2'b01 : 2'b11) || bus_err !== 1'b0) begin errors++; $display("FAIL to_wait%0d: got iwait=%b bus_err=%b", g, iwait, bus_err); end
    end
    tick();
    iREN = '0;
    @(negedge CLK);
    checks++; if (bus_err !== 1'b1 || {ramREN, ramWEN} !== 2'b00) begin errors++; $display("FAIL to_release: got bus_err=%b en=%b expected 1/00", bus_err, {ramREN, ramWEN}); end
    tick();
    @(negedge CLK);
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", bus_err); end
  endtask

  task automatic test_error();
    do_reset();
    @(negedge CLK);
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", bus_err); end
    dREN = 2'b01;
    daddr[31:0] = 32'h600;
    ramstate = ERROR;
    ramload = 32'h0000_9999;
    push(1'b1, 2'd0, BAD_LOAD);
    tick();
    @(negedge CLK);
    checks++; if (dwait !== 2'b10) begin errors++; $display("FAIL err_dwait: got %b expected 10", dwait); end
    checks++; if (dload !== {2{BAD_LOAD}} || iload[31:0] !== BAD_LOAD) begin errors++; $display("FAIL err_load: got %h/%h expected bad1bad1", dload, iload[31:0]); end
    tick();
    dREN = '0;
    ramstate = FREE;
    @(negedge CLK);
    checks++; if (bus_err !== 1'b1 || dload[31:0] !== 32'h0000_9999) begin errors++; $display("FAIL err_after: got bus_err=%b dload=%h expected 1/00009999", bus_err, dload[31:0]); end
  endtask

  task automatic test_abort();
    dREN = 2'b10;
    daddr[63:32] = 32'h700;
    ramstate = BUSY;
    tick();
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h700 || dwait !== 2'b11) begin errors++; $display("FAIL abort_grant: got ren=%b addr=%h dwait=%b", ramREN, ramaddr, dwait); end
    tick();
    dREN = '0;
    @(negedge CLK);
    checks++; if ({ramREN, ramWEN} !== 2'b00 || dwait !== 2'b11) begin errors++; $display("FAIL abort_drop: got en=%b dwait=%b expected 00/11", {ramREN, ramWEN}, dwait); end
    tick();
    @(negedge CLK);
    // Pointer still at core1: core1 must win a tie.
    dREN = 2'b11;
    daddr = {32'h0000_0700, 32'h0000_0200};
    ramstate = ACCESS;
    ramload = 32'h0000_4444;
    push(1'b1, 2'd1, 32'h0000_4444);
    tick();
    @(negedge CLK);
    checks++; if (dwait !== 2'b01 || ramaddr !== 32'h700) begin errors++; $display("FAIL abort_ptr: got dwait=%b addr=%h expected 01/700", dwait, ramaddr); end
    tick();
    dREN = '0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    iREN = 2'b01;
    iaddr[31:0] = 32'h40;
    ramstate = ACCESS;
    ramload = 32'h0000_1111;
    push(1'b0, 2'd0, 32'h0000_1111);
    tick();
    @(negedge CLK);
    checks++; if (iwait !== 2'b10) begin errors++; $display("FAIL rmid_pre: got %b expected 10", iwait); end
    tick();
    iREN = 2'b10;
    iaddr[63:32] = 32'h800;
    ramstate = BUSY;
    tick();
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h800) begin errors++; $display("FAIL rmid_grant: got ren=%b addr=%h expected 1/800", ramREN, ramaddr); end
    #2 nRST = 1'b0;
    #1;
    checks++; if ({ramREN, ramWEN} !== 2'b00 || ramaddr !== 32'h0) begin errors++; $display("FAIL rmid_bus: got en=%b addr=%h expected 00/0", {ramREN, ramWEN}, ramaddr); end
    checks++; if (iwait !== 2'b11 || dwait !== 2'b11) begin errors++; $display("FAIL rmid_wait: got %b/%b expected 11/11", iwait, dwait); end
    iREN = '0;
    @(posedge CLK);
    #1 nRST = 1'b1;
    dREN = 2'b11;
    daddr = {32'h0000_0310, 32'h0000_0210};
    ramstate = ACCESS;
    ramload = 32'h0000_2222;
    push(1'b1, 2'd0, 32'h0000_2222);
    tick();
    @(negedge CLK);
    checks++; if (dwait !== 2'b10 || ramaddr !== 32'h210) begin errors++; $display("FAIL rmid_fresh: got dwait=%b addr=%h expected 10/210", dwait, ramaddr); end
    tick();
    dREN = '0;
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_single_read();
    test_priority();
    test_timeout();
    test_error();
    test_abort();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL cpl_leftover: %0d completions outstanding, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
